// File: rtl/llc_req_queue_if.sv
// Bundle of the crossbar-side and LLC-side request handshakes for llc_req_queue.
// The queue takes the slave view; whoever drives requests and consumes LLC traffic takes the master view.
interface llc_req_queue_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 2
);
  logic [3:0]              up_v;
  logic [3:0]              up_r;
  logic [4*DATA_W-1:0]     up_d;
  logic [3:0]              llc_so;
  logic [3:0]              llc_ro;
  logic [4*DATA_W-1:0]     llc_do;
  logic [3:0]              lane_en;
  logic [4*(ADDR_W+1)-1:0] lane_cnt;

  modport slave (
    input  up_v, up_d, llc_ro, lane_en,
    output up_r, llc_so, llc_do, lane_cnt
  );

  modport master (
    output up_v, up_d, llc_ro, lane_en,
    input  up_r, llc_so, llc_do, lane_cnt
  );
endinterface

// File: rtl/llc_req_queue.sv
// Four independent request FIFOs between crossbar LLC outputs and the LLC proxy.
// Each lane buffers up to 2**ADDR_W requests and can be held with lane_en.
module llc_req_queue #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 2
) (
  input logic              clk,
  input logic              reset,
  llc_req_queue_if.slave   bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam cnt_t CntFull = cnt_t'(Depth);

  data_t mem_q [4][Depth];
  data_t mem_d [4][Depth];
  ptr_t  wr_ptr_q [4];
  ptr_t  wr_ptr_d [4];
  ptr_t  rd_ptr_q [4];
  ptr_t  rd_ptr_d [4];
  cnt_t  cnt_q [4];
  cnt_t  cnt_d [4];

  logic [3:0] up_r;
  logic [3:0] llc_so;
  logic [3:0] push;
  logic [3:0] pop;

  // up_r comes only from registered count, so full never bypasses on a same-cycle pop.
  always_comb begin
    up_r   = '0;
    llc_so = '0;
    push   = '0;
    pop    = '0;
    for (int i = 0; i < 4; i++) begin
      up_r[i]   = (cnt_q[i] != CntFull);
      llc_so[i] = (cnt_q[i] != '0) && bus.lane_en[i];
      push[i]   = bus.up_v[i] && up_r[i];
      pop[i]    = llc_so[i] && bus.llc_ro[i];
    end
  end

  always_comb begin
    bus.up_r     = up_r;
    bus.llc_so   = llc_so;
    bus.llc_do   = '0;
    bus.lane_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      // Empty lanes present zero so stale storage never leaks out after reset.
      if (cnt_q[i] != '0) begin
        bus.llc_do[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i]];
      end
      bus.lane_cnt[i*CntW +: CntW] = cnt_q[i];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.up_d[i*DATA_W +: DATA_W];
        wr_ptr_d[i]           = wr_ptr_q[i] + ptr_t'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(1);
      end
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_llc_req_queue.sv
// Directed bench for llc_req_queue: fill/drain, wrap streaming, push+pop, gating, mid-run reset.
module tb_llc_req_queue;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = AW + 1;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  llc_req_queue_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  llc_req_queue #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_d(input int lane, input logic [DW-1:0] val);
    bus.up_d[lane*DW +: DW] = val;
  endtask

  function automatic logic [DW-1:0] do_lane(input int lane);
    return bus.llc_do[lane*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt_lane(input int lane);
    return bus.lane_cnt[lane*CW +: CW];
  endfunction

  logic [DW-1:0] exp0 [4];
  int            fillc [4];

  initial begin
    reset       = 1'b1;
    bus.up_v    = '0;
    bus.up_d    = '0;
    bus.llc_ro  = '0;
    bus.lane_en = 4'hF;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset.
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("idle%0d up_r", k), bus.up_r, 4'hF);
      check($sformatf("idle%0d llc_so", k), bus.llc_so, 4'h0);
      check($sformatf("idle%0d lane_cnt", k), bus.lane_cnt, '0);
      check($sformatf("idle%0d llc_do_lo", k), bus.llc_do[127:0] == '0, 1'b1);
      check($sformatf("idle%0d llc_do_hi", k), bus.llc_do[255:128] == '0, 1'b1);
      tick();
    end

    // Lane 0 fill to full, then reject a fifth push.
    exp0[0] = 64'h11; exp0[1] = 64'h22; exp0[2] = 64'h33; exp0[3] = 64'h44;
    for (int k = 0; k < 4; k++) begin
      bus.up_v[0] = 1'b1;
      set_d(0, exp0[k]);
      tick();
    end
    settle();
    check("l0 full cnt", cnt_lane(0), 4);
    check("l0 full up_r", bus.up_r[0], 1'b0);
    set_d(0, 64'h55);
    tick();
    bus.up_v[0] = 1'b0;
    settle();
    check("l0 reject cnt", cnt_lane(0), 4);
    check("l0 reject head", do_lane(0), 64'h11);

    bus.llc_ro[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("l0 drain%0d so", k), bus.llc_so[0], 1'b1);
      check($sformatf("l0 drain%0d do", k), do_lane(0), exp0[k]);
      tick();
      if (k == 0) check("l0 up_r after pop", bus.up_r[0], 1'b1);
    end
    settle();
    check("l0 empty so", bus.llc_so[0], 1'b0);
    check("l0 empty cnt", cnt_lane(0), 0);
    check("l0 empty do", do_lane(0), 64'h0);
    bus.llc_ro[0] = 1'b0;

    // Lane 2 streaming through pointer wrap.
    bus.llc_ro[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.up_v[2] = 1'b1;
      set_d(2, DW'(k));
      settle();
      if (k > 0) begin
        check($sformatf("l2 stream%0d do", k), do_lane(2), DW'(k - 1));
        check($sformatf("l2 stream%0d cnt", k), cnt_lane(2), 1);
        check($sformatf("l2 stream%0d so", k), bus.llc_so[2], 1'b1);
      end else begin
        check("l2 stream0 so", bus.llc_so[2], 1'b0);
      end
      tick();
    end
    bus.up_v[2] = 1'b0;
    settle();
    check("l2 last do", do_lane(2), 64'd9);
    check("l2 last cnt", cnt_lane(2), 1);
    tick();
    check("l2 drained cnt", cnt_lane(2), 0);
    bus.llc_ro[2] = 1'b0;

    // Lane 1: push+pop at cnt 2, then push+pop into full.
    bus.up_v[1] = 1'b1;
    set_d(1, 64'hA1); tick();
    set_d(1, 64'hA2); tick();
    set_d(1, 64'hA3);
    bus.llc_ro[1] = 1'b1;
    settle();
    check("l1 pre cnt", cnt_lane(1), 2);
    tick();
    bus.llc_ro[1] = 1'b0;
    settle();
    check("l1 pushpop cnt", cnt_lane(1), 2);
    check("l1 pushpop head", do_lane(1), 64'hA2);
    set_d(1, 64'hA4); tick();
    set_d(1, 64'hA5); tick();
    set_d(1, 64'hA6);
    bus.llc_ro[1] = 1'b1;
    settle();
    check("l1 full up_r", bus.up_r[1], 1'b0);
    check("l1 full cnt", cnt_lane(1), 4);
    tick();
    bus.up_v[1] = 1'b0;
    settle();
    check("l1 full pop cnt", cnt_lane(1), 3);
    exp0[0] = 64'hA3; exp0[1] = 64'hA4; exp0[2] = 64'hA5;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("l1 drain%0d do", k), do_lane(1), exp0[k]);
      tick();
    end
    check("l1 drained so", bus.llc_so[1], 1'b0);
    check("l1 drained cnt", cnt_lane(1), 0);
    bus.llc_ro[1] = 1'b0;

    // Lane 3 gating.
    bus.lane_en[3] = 1'b0;
    bus.llc_ro[3]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.up_v[3] = 1'b1;
      set_d(3, 64'h31 + DW'(k));
      tick();
      check($sformatf("l3 gated%0d so", k), bus.llc_so[3], 1'b0);
      check($sformatf("l3 gated%0d others", k), {bus.llc_so[2:0], bus.up_r[2:0]}, 6'b000111);
    end
    bus.up_v[3] = 1'b0;
    settle();
    check("l3 gated cnt", cnt_lane(3), 3);
    check("l3 gated head", do_lane(3), 64'h31);
    bus.lane_en[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("l3 drain%0d so", k), bus.llc_so[3], 1'b1);
      check($sformatf("l3 drain%0d do", k), do_lane(3), 64'h31 + DW'(k));
      tick();
    end
    check("l3 drained so", bus.llc_so, 4'h0);
    check("l3 drained cnt", bus.lane_cnt, '0);
    bus.llc_ro[3] = 1'b0;

    // Load lanes with 2,4,1,3 entries, then reset mid-operation.
    fillc[0] = 2; fillc[1] = 4; fillc[2] = 1; fillc[3] = 3;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        bus.up_v[i] = (k < fillc[i]);
        set_d(i, 64'hF00 + DW'(16 * i + k));
      end
      tick();
    end
    bus.up_v = '0;
    settle();
    check("pre-reset cnt", bus.lane_cnt, {3'd3, 3'd1, 3'd4, 3'd2});
    check("pre-reset so", bus.llc_so, 4'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.llc_ro = 4'hF;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("post-reset%0d cnt", k), bus.lane_cnt, '0);
      check($sformatf("post-reset%0d so", k), bus.llc_so, 4'h0);
      check($sformatf("post-reset%0d up_r", k), bus.up_r, 4'hF);
      check($sformatf("post-reset%0d do", k), bus.llc_do == '0, 1'b1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/llc_req_queue.md
Name: llc_req_queue

Overview:
- Four independent per-lane request FIFOs between the crossbar's LLC-bound outputs and the LLC proxy's request inputs (llc_so/llc_ro/llc_do).
- Absorbs LLC busy periods so the crossbar is not stalled by per-port LLC latency.
- Provides per-lane occupancy and per-lane drain gating.
- Upstream and downstream both use valid/ready; a transfer occurs when valid and ready are high on the same rising edge.

Parameters:
DATA_W, 64, request payload width per lane
ADDR_W, 2, log2 of per-lane FIFO depth; DEPTH = 2**ADDR_W (default 4), ADDR_W >= 1

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
up_v  input  4  per-lane request valid from crossbar
up_r  output  4  per-lane ready to crossbar
up_d  input  4*DATA_W  per-lane request data, lane i at [DATA_W*(i+1)-1 : DATA_W*i]
llc_so  output  4  per-lane request valid to LLC
llc_ro  input  4  per-lane LLC ready
llc_do  output  4*DATA_W  per-lane request data to LLC, same packing as up_d
lane_en  input  4  per-lane drain enable; 0 holds the lane's queue
lane_cnt  output  4*(ADDR_W+1)  per-lane occupancy 0..DEPTH, lane i at [(ADDR_W+1)*(i+1)-1 : (ADDR_W+1)*i]

Behaviour:
- Lanes are fully independent. Each lane has storage mem[DEPTH], wr_ptr and rd_ptr (ADDR_W bits), and cnt (ADDR_W+1 bits).
- Reset, synchronous: wr_ptr = rd_ptr = cnt = 0 on all lanes. Storage is not reset.
  - Cycle after reset: up_r = 4'b1111, llc_so = 4'b0000, llc_do = 0, lane_cnt = 0.
  - Reset asserted mid-operation discards all queued entries. Nothing is delivered after reset deasserts.
- up_r[i] = (cnt_i != DEPTH). It depends only on registered state: no combinational path from llc_ro or lane_en to up_r.
- llc_so[i] = (cnt_i != 0) & lane_en[i].
- llc_do lane i = mem_i[rd_ptr_i] when cnt_i != 0; otherwise all-zero.
- lane_cnt lane i = cnt_i.
- Push: up_v[i] & up_r[i]. Writes up_d lane i to mem_i[wr_ptr_i]; wr_ptr_i increments.
- Pop: llc_so[i] & llc_ro[i]. rd_ptr_i increments.
- Pointers wrap modulo DEPTH by natural ADDR_W-bit overflow.
- cnt update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
  - neither: unchanged
- Full (cnt = DEPTH):
  - up_r = 0 and no push occurs, even if a pop happens the same cycle. There is no full-bypass.
  - up_r returns to 1 the cycle after the first pop.
- Empty (cnt = 0):
  - llc_so = 0 and no pop occurs.
  - A push into an empty lane is visible on llc_so/llc_do the following cycle.
  - Minimum latency up_v -> llc_so is 1 cycle. No flow-through.
- Ordering: strict FIFO per lane; no cross-lane ordering.
- lane_en[i] = 0:
  - llc_so[i] is forced to 0 and no pop occurs.
  - Pushes continue until full.
  - Head data remains visible on llc_do.
  - lane_en may change on any cycle; on re-enable, llc_so rises combinationally the same cycle if cnt != 0.
- Downstream valid stability: once llc_so[i] = 1 with lane_en[i] held high, llc_so[i] and llc_do lane i stay stable until popped.
- Upstream inputs are ignored when up_r = 0. No overflow or underflow is possible; no error outputs.
- Throughput: with no stalls, a lane sustains one push and one pop per cycle indefinitely.

Test Plan:
- Reset, then idle: up_r = 4'hF, llc_so = 0, lane_cnt all 0, llc_do = 0 for 3 cycles.
- Lane 0 in-order fill and drain:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with llc_ro[0] = 0. lane_cnt0 reaches 4 and up_r[0] = 0; a 5th push of 0x55 is rejected.
  - Raise llc_ro[0]. llc_do0 shows 0x11, 0x22, 0x33, 0x44 on successive cycles; llc_so[0] falls after 4 pops.
  - up_r[0] returns to 1 the cycle after the first pop.
- Streaming with wrap:
  - Lane 2, ready held high, push 10 values 0..9 back-to-back.
  - Each value appears on llc_do2 one cycle after its push; lane_cnt2 stays 1; all values arrive in order through the pointer wrap.
- Simultaneous push/pop at cnt = 2 on lane 1 leaves cnt at 2 and preserves order. Push into a full lane while a pop happens the same cycle is rejected (cnt goes 4 -> 3).
- Lane gating:
  - Lane 3, lane_en[3] = 0, push 3 entries with llc_ro[3] = 1. llc_so[3] stays 0 and lane_cnt3 = 3.
  - Set lane_en[3] = 1. Entries drain over 3 cycles in order; other lanes are unaffected throughout.
- Reset mid-operation: with lanes holding 2, 4, 1, 3 entries, assert reset for 1 cycle. The next cycle shows all lane_cnt = 0, llc_so = 0, up_r = 4'hF, and no stale data is ever presented.
